// File: rtl/edge_frame_capture_if.sv
// edge_frame_capture_if: video input stream and packed-bitmap read port
// master drives i_vsync/i_hsync/i_de/i_data and i_rd_en/i_rd_addr, slave returns o_rd_data
interface edge_frame_capture_if #(
    parameter int WIDTH = 8,
    parameter int AW = 13
);
    logic i_vsync;
    logic i_hsync;
    logic i_de;
    logic [WIDTH-1:0] i_data;
    logic i_rd_en;
    logic [AW-1:0] i_rd_addr;
    logic [7:0] o_rd_data;
    modport master (output i_vsync, i_hsync, i_de, i_data, i_rd_en, i_rd_addr, input o_rd_data);
    modport slave (input i_vsync, i_hsync, i_de, i_data, i_rd_en, i_rd_addr, output o_rd_data);
endinterface

// File: rtl/edge_frame_capture.sv
// edge_frame_capture: thresholds one edge-magnitude frame into a 1-bit-per-pixel bitmap
// clk/rstn (async, active-low); bus: video in + bitmap read port; i_start/i_thr arm a capture;
// o_busy armed or capturing, o_done one-cycle frame-stored pulse, o_err sticky framing error
module edge_frame_capture #(
    parameter int WIDTH = 8,
    parameter int H_RES = 172,
    parameter int V_RES = 240
) (
    input  logic clk,
    input  logic rstn,
    edge_frame_capture_if.slave bus,
    input  logic i_start,
    input  logic [WIDTH-1:0] i_thr,
    output logic o_busy,
    output logic o_done,
    output logic o_err
);
    localparam int NPIX = H_RES * V_RES;
    localparam int DEPTH = NPIX / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(NPIX + 1);
    localparam int CW = $clog2(H_RES + 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);
    localparam logic [CW-1:0] COL_END = CW'(H_RES);
    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] thr_q;
    logic vs_q, de_q, err_q;
    logic [PW-1:0] pix_cnt;
    logic [CW-1:0] col_cnt;
    logic [AW-1:0] wr_addr;
    logic [7:0] pack, pack_nx, rd_data;
    logic [7:0] mem [DEPTH];
    logic vs_rise, in_cap, de_fall, err, acc, wr_en, last;
    logic unused_hsync;
    assign unused_hsync = bus.i_hsync;
    always_comb begin
        vs_rise = bus.i_vsync & ~vs_q;
        in_cap = state == CAPTURE;
        de_fall = in_cap & de_q & ~bus.i_de;
        // short frame, short line, long line
        err = in_cap & (vs_rise | (de_fall & col_cnt != COL_END) | (bus.i_de & col_cnt == COL_END));
        acc = in_cap & bus.i_de & ~err;
        // first pixel of each group of 8 starts a fresh byte at bit 0
        pack_nx = (pix_cnt[2:0] == 3'd0 ? 8'h00 : pack) | (8'(bus.i_data >= thr_q) << pix_cnt[2:0]);
        wr_en = acc & pix_cnt[2:0] == 3'd7;
        last = acc & pix_cnt == PIX_LAST;
        state_nx = (state == IDLE && i_start) ? ARM :
                   (state == ARM && vs_rise) ? CAPTURE :
                   (in_cap && err) ? IDLE :
                   (in_cap && last) ? DONE :
                   (state == DONE) ? IDLE : state;
        o_busy = state == ARM || state == CAPTURE;
        o_done = state == DONE;
        o_err = err_q;
        bus.o_rd_data = rd_data;
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            thr_q <= '0;
            vs_q <= 1'b0;
            de_q <= 1'b0;
            err_q <= 1'b0;
            pix_cnt <= '0;
            col_cnt <= '0;
            wr_addr <= '0;
            pack <= '0;
            rd_data <= '0;
        end else begin
            vs_q <= bus.i_vsync;
            // only edges seen inside CAPTURE count as line ends
            de_q <= in_cap & bus.i_de;
            if (bus.i_rd_en) rd_data <= mem[bus.i_rd_addr];
            if (state == IDLE && i_start) begin
                thr_q <= i_thr;
                err_q <= 1'b0;
            end
            if (err) err_q <= 1'b1;
            if (state == ARM && vs_rise) begin
                pix_cnt <= '0;
                col_cnt <= '0;
                wr_addr <= '0;
                pack <= '0;
            end
            if (acc) begin
                pack <= pack_nx;
                pix_cnt <= pix_cnt + PW'(1);
                col_cnt <= col_cnt + CW'(1);
                if (wr_en) wr_addr <= wr_addr + AW'(1);
            end else if (de_fall) col_cnt <= '0;
        end
    end
    // bitmap storage is deliberately outside reset
    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= pack_nx;
endmodule

// File: doc/edge_frame_capture.md
EDGE_FRAME_CAPTURE -- requirements
Module: edge_frame_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 8: pixel data width.
REQ-002 SHALL have parameter H_RES, default 172: active pixels per line.
REQ-003 SHALL have parameter V_RES, default 240: active lines per frame.
REQ-004 SHALL constrain H_RES*V_RES to a multiple of 8, with DEPTH = H_RES*V_RES/8 words and AW = $clog2(DEPTH).
REQ-005 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-006 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports i_vsync, i_hsync, i_de (input, 1 each) and i_data (input, WIDTH): incoming edge-magnitude video stream; i_vsync is active-high during vertical blank; i_hsync is ignored.
REQ-008 SHALL have port i_start, input, 1: single-cycle capture request.
REQ-009 SHALL have port i_thr, input, WIDTH: binarization threshold.
REQ-010 SHALL have port o_busy, output, 1: capture armed or in progress.
REQ-011 SHALL have port o_done, output, 1: one-cycle pulse when a full frame is stored.
REQ-012 SHALL have port o_err, output, 1: sticky framing error.
REQ-013 SHALL have ports i_rd_en (input, 1), i_rd_addr (input, AW) and o_rd_data (output, 8): packed-bitmap read port.

Function
REQ-014 SHALL implement the FSM states IDLE, ARM, CAPTURE and DONE.
REQ-015 SHALL, in IDLE, move to ARM when i_start=1, latching i_thr into thr_q and clearing o_err.
REQ-016 SHALL ignore i_start in every state other than IDLE.
REQ-017 SHALL, in ARM, detect a rising edge of i_vsync (registered previous value 0, current value 1) and then enter CAPTURE with pixel, column and word counters cleared.
REQ-018 SHALL ignore i_de while in ARM.
REQ-019 SHALL, in CAPTURE on each cycle with i_de=1, form the bit (i_data >= thr_q) and shift it into an 8-bit pack register LSB-first; the first pixel of each group of 8 lands in bit 0.
REQ-020 SHALL write the completed byte to bitmap word wr_addr on every 8th accepted pixel, in the same cycle that pixel is accepted, then increment wr_addr.
REQ-021 SHALL increment the column counter on each accepted pixel and clear it on the i_de falling edge.
REQ-022 SHALL set o_err and return to IDLE if i_de falls while the column counter is not equal to H_RES (short line).
REQ-023 SHALL set o_err and return to IDLE if i_de is still high after H_RES pixels without a falling edge (long line).
REQ-024 SHALL set o_err and return to IDLE if an i_vsync rising edge occurs in CAPTURE before H_RES*V_RES pixels have been accepted (short frame).
REQ-025 SHALL, on an error, keep the words already written and discard the partial pack register.
REQ-026 SHALL, when pixel H_RES*V_RES is accepted, write the final word and enter DONE on the next edge.
REQ-027 SHALL, in DONE, assert o_done for exactly 1 cycle and return to IDLE on the following edge.
REQ-028 SHALL drive o_busy=1 exactly in ARM and CAPTURE.
REQ-029 SHALL, when i_rd_en=1, update o_rd_data one cycle later with mem[i_rd_addr]; o_rd_data SHALL hold its value when i_rd_en=0.
REQ-030 SHALL allow reads in every state.
REQ-031 SHALL, on a same-cycle read and write to the same address, return the old word (read-first).
REQ-032 SHALL treat an out-of-range read address (>= DEPTH) as undefined data and leave all state unchanged.
REQ-033 SHALL give a pixel accepted at cycle t visibility via the read port starting at t+1, i.e. once its word has been written.

Reset
REQ-034 SHALL, on rstn=0, asynchronously force state=IDLE, o_busy=0, o_done=0, o_err=0, o_rd_data=0, all counters=0, pack register=0, thr_q=0 and the registered vsync=0.
REQ-035 SHALL leave bitmap memory contents unchanged by reset.
REQ-036 SHALL, on reset asserted mid-CAPTURE, abandon the frame; a new i_start is needed after release.

Verification (bench uses H_RES=8, V_RES=4, WIDTH=8)
REQ-037 SHALL cover: start with thr=0x80, vsync pulse, 4 lines of data 0x00,0xFF alternating -> words 0..3 each read 0xAA, one o_done pulse, o_busy falls with DONE, o_err=0.
REQ-038 SHALL cover: thr=0x10 with all pixels 0x10 -> all words 0xFF (equality counts as edge); all pixels 0x0F -> all words 0x00.
REQ-039 SHALL cover: line 2 has only 7 de cycles -> o_err=1, state IDLE, no o_done, words 0..1 intact; the next i_start clears o_err.
REQ-040 SHALL cover: i_de toggling before the first vsync edge in ARM -> no writes; i_start pulsed during CAPTURE -> no effect and thr_q unchanged.
REQ-041 SHALL cover: rstn low at pixel 13 of CAPTURE -> all outputs 0 immediately; after release, reading word 0 returns the previously captured byte.
REQ-042 SHALL cover: reading word 1 in the same cycle it is written -> old value returned; a re-read 1 cycle later returns the new value.
